// File: rtl/vec_cache_mp.sv
// Multi-port vector register cache: NUM_READ registered read ports, one direct write
// port and a beat-serial fill engine. Lanes hold IEEE-754 single-precision bit patterns.

typedef enum logic [1:0] {
    RD_DISABLE = 2'd0,
    RD_SCALAR  = 2'd1,
    RD_VEC     = 2'd2
} VecDataReadOp_t;

typedef enum logic [1:0] {
    WR_DISABLE = 2'd0,
    WR_SCALAR  = 2'd1,
    WR_VEC     = 2'd2
} VecDataWriteOp_t;

module vec_cache_mp #(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned CACHE_SIZE = 8,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned BEAT       = 16,
    localparam int unsigned NBEATS          = WIDTH / BEAT,
    localparam int unsigned WIDTH_ADDR_SIZE = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int unsigned CACHE_ADDR_SIZE = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1,
    localparam int unsigned BEAT_CNT_SIZE   = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  VecDataReadOp_t             read_op    [NUM_READ],
    input  logic [CACHE_ADDR_SIZE-1:0] read_addr  [NUM_READ],
    input  logic [WIDTH_ADDR_SIZE-1:0] read_param [NUM_READ],
    output logic [31:0]                data_out   [NUM_READ][WIDTH],
    input  VecDataWriteOp_t            write_op,
    input  logic [CACHE_ADDR_SIZE-1:0] write_addr,
    input  logic [WIDTH_ADDR_SIZE-1:0] write_param,
    input  logic [31:0]                data_in    [WIDTH],
    output logic                       write_conflict,
    input  logic                       fill_start,
    input  logic [CACHE_ADDR_SIZE-1:0] fill_addr,
    input  logic                       fill_valid,
    output logic                       fill_ready,
    input  logic [31:0]                fill_data  [BEAT],
    output logic                       fill_busy,
    output logic                       fill_done
);

    typedef enum logic {S_IDLE, S_FILL} fill_state_t;

    fill_state_t                r_state;
    logic [CACHE_ADDR_SIZE-1:0] r_fill_addr;
    logic [BEAT_CNT_SIZE-1:0]   r_beat_cnt;
    logic                       r_fill_ready;
    logic                       r_fill_busy;
    logic                       r_fill_done;
    logic                       r_write_conflict;
    logic [31:0]                r_mem      [CACHE_SIZE][WIDTH];
    logic [31:0]                r_data_out [NUM_READ][WIDTH];
    logic [31:0]                w_mem_nxt  [CACHE_SIZE][WIDTH];
    logic                       w_accept;
    logic                       w_last_beat;
    logic                       w_wr_conflict;

    assign w_accept      = (r_state == S_FILL) && fill_valid;
    assign w_last_beat   = (r_beat_cnt == BEAT_CNT_SIZE'(NBEATS - 1));
    assign w_wr_conflict = (r_state == S_FILL) && (write_op != WR_DISABLE)
                           && (write_addr == r_fill_addr);

    assign data_out       = r_data_out;
    assign write_conflict = r_write_conflict;
    assign fill_ready     = r_fill_ready;
    assign fill_busy      = r_fill_busy;
    assign fill_done      = r_fill_done;

    // Post-edge register file image; reads sample it so same-cycle writes/beats are seen.
    always_comb begin
        w_mem_nxt = r_mem;
        if (!w_wr_conflict) begin
            case (write_op)
                WR_SCALAR: w_mem_nxt[write_addr][write_param] = data_in[write_param];
                WR_VEC:    w_mem_nxt[write_addr] = data_in;
                default:   ;
            endcase
        end
        if (w_accept) begin
            for (int b = 0; b < int'(BEAT); b++) begin
                w_mem_nxt[r_fill_addr][WIDTH_ADDR_SIZE'(32'(r_beat_cnt) * BEAT + 32'(b))] =
                    fill_data[b];
            end
        end
    end

    // Storage and registered read ports.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(CACHE_SIZE); c++) begin
                for (int l = 0; l < int'(WIDTH); l++) begin
                    r_mem[c][l] <= '0;
                end
            end
            for (int p = 0; p < int'(NUM_READ); p++) begin
                for (int l = 0; l < int'(WIDTH); l++) begin
                    r_data_out[p][l] <= '0;
                end
            end
        end else begin
            r_mem <= w_mem_nxt;
            for (int p = 0; p < int'(NUM_READ); p++) begin
                for (int l = 0; l < int'(WIDTH); l++) begin
                    case (read_op[p])
                        RD_VEC:    r_data_out[p][l] <= w_mem_nxt[read_addr[p]][l];
                        RD_SCALAR: r_data_out[p][l] <= w_mem_nxt[read_addr[p]][read_param[p]];
                        default:   r_data_out[p][l] <= '0;
                    endcase
                end
            end
        end
    end

    // Fill engine: owns the latched register until the last beat is committed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_fill_addr      <= '0;
            r_beat_cnt       <= '0;
            r_fill_ready     <= 1'b0;
            r_fill_busy      <= 1'b0;
            r_fill_done      <= 1'b0;
            r_write_conflict <= 1'b0;
        end else begin
            r_fill_done      <= 1'b0;
            r_write_conflict <= w_wr_conflict;
            case (r_state)
                S_IDLE: begin
                    if (fill_start) begin
                        r_state      <= S_FILL;
                        r_fill_addr  <= fill_addr;
                        r_beat_cnt   <= '0;
                        r_fill_ready <= 1'b1;
                        r_fill_busy  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_CNT_SIZE'(1);
                        if (w_last_beat) begin
                            r_state      <= S_IDLE;
                            r_fill_ready <= 1'b0;
                            r_fill_busy  <= 1'b0;
                            r_fill_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_cache_mp.sv
// Self-checking bench for vec_cache_mp: constant vector table, hand-written fill/reset
// sequences and a randomized phase, all checked against a register-file reference model.
`timescale 1ns/1ps
module tb_vec_cache_mp;

    localparam int W  = 128;
    localparam int C  = 8;
    localparam int NR = 2;
    localparam int B  = 16;
    localparam int NB = W / B;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    VecDataReadOp_t  read_op    [NR];
    logic [2:0]      read_addr  [NR];
    logic [6:0]      read_param [NR];
    logic [31:0]     data_out   [NR][W];
    VecDataWriteOp_t write_op;
    logic [2:0]      write_addr;
    logic [6:0]      write_param;
    logic [31:0]     data_in    [W];
    logic            write_conflict;
    logic            fill_start;
    logic [2:0]      fill_addr;
    logic            fill_valid;
    logic            fill_ready;
    logic [31:0]     fill_data  [B];
    logic            fill_busy;
    logic            fill_done;

    vec_cache_mp dut (
        .clock(clock), .reset_n(reset_n),
        .read_op(read_op), .read_addr(read_addr), .read_param(read_param),
        .data_out(data_out),
        .write_op(write_op), .write_addr(write_addr), .write_param(write_param),
        .data_in(data_in), .write_conflict(write_conflict),
        .fill_start(fill_start), .fill_addr(fill_addr), .fill_valid(fill_valid),
        .fill_ready(fill_ready), .fill_data(fill_data), .fill_busy(fill_busy),
        .fill_done(fill_done)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain register file plus fill ownership bookkeeping.
    logic [31:0] m_mem [C][W];
    bit          m_on;
    int          m_reg;
    int          m_beat;
    logic [31:0] e_out [NR][W];
    bit          e_done;
    bit          e_conf;

    function automatic logic [31:0] f2b(real x);
        logic [63:0] d;
        if (x == 0.0) return 32'h0;
        d = $realtobits(x);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < C; c++)
            for (int l = 0; l < W; l++) m_mem[c][l] = '0;
        m_on = 0; m_reg = 0; m_beat = 0;
    endtask

    task automatic check_model();
        for (int p = 0; p < NR; p++) begin
            int bad;
            bad = -1;
            for (int l = W - 1; l >= 0; l--)
                if (data_out[p][l] !== e_out[p][l]) bad = l;
            n_vec++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL data_out[%0d] lane %0d: got %h expected %h",
                         p, bad, data_out[p][bad], e_out[p][bad]);
            end
        end
        n_vec++;
        if ({fill_ready, fill_busy, fill_done, write_conflict} !== {m_on, m_on, e_done, e_conf}) begin
            n_err++;
            $display("FAIL flags rdy/busy/done/conf: got %b%b%b%b expected %b%b%b%b",
                     fill_ready, fill_busy, fill_done, write_conflict,
                     m_on, m_on, e_done, e_conf);
        end
    endtask

    // Apply current inputs for one edge, advance the model, then check outputs.
    task automatic step();
        bit acc, conf;
        acc  = m_on && fill_valid;
        conf = m_on && (write_op != WR_DISABLE) && (int'(write_addr) == m_reg);
        if (!conf) begin
            if (write_op == WR_VEC)
                for (int l = 0; l < W; l++) m_mem[write_addr][l] = data_in[l];
            else if (write_op == WR_SCALAR)
                m_mem[write_addr][write_param] = data_in[write_param];
        end
        if (acc)
            for (int b = 0; b < B; b++) m_mem[m_reg][m_beat * B + b] = fill_data[b];
        for (int p = 0; p < NR; p++)
            for (int l = 0; l < W; l++)
                case (read_op[p])
                    RD_VEC:    e_out[p][l] = m_mem[read_addr[p]][l];
                    RD_SCALAR: e_out[p][l] = m_mem[read_addr[p]][read_param[p]];
                    default:   e_out[p][l] = '0;
                endcase
        e_conf = conf;
        e_done = acc && (m_beat == NB - 1);
        if (acc) begin
            m_beat++;
            if (m_beat == NB) m_on = 0;
        end else if (!m_on && fill_start) begin
            m_on = 1; m_reg = int'(fill_addr); m_beat = 0;
        end
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic set_idle();
        for (int p = 0; p < NR; p++) begin
            read_op[p] = RD_DISABLE; read_addr[p] = '0; read_param[p] = '0;
        end
        write_op = WR_DISABLE; write_addr = '0; write_param = '0;
        for (int l = 0; l < W; l++) data_in[l] = '0;
        fill_start = 1'b0; fill_addr = '0; fill_valid = 1'b0;
        for (int b = 0; b < B; b++) fill_data[b] = '0;
    endtask

    task automatic set_write(VecDataWriteOp_t op, int addr, int param, real scale);
        write_op = op; write_addr = 3'(addr); write_param = 7'(param);
        for (int l = 0; l < W; l++) data_in[l] = f2b(scale * l);
    endtask

    task automatic set_beat(real v);
        for (int b = 0; b < B; b++) fill_data[b] = f2b(v);
    endtask

    task automatic set_read(int p, VecDataReadOp_t op, int addr, int param);
        read_op[p] = op; read_addr[p] = 3'(addr); read_param[p] = 7'(param);
    endtask

    typedef struct {
        VecDataReadOp_t  rop0; int ra0; int rp0;
        VecDataReadOp_t  rop1; int ra1; int rp1;
        VecDataWriteOp_t wop;  int wa;  int wp;  real scale;
        int lane; real exp0; real exp1;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int done_at, done_cnt;

        tbl[0] = '{RD_VEC,     3, 0,   RD_VEC,    3, 0,   WR_DISABLE, 0, 0, 0.0, 7,  0.0,  0.0};
        tbl[1] = '{RD_VEC,     2, 0,   RD_SCALAR, 2, 5,   WR_VEC,     2, 0, 1.0, 9,  9.0,  5.0};
        tbl[2] = '{RD_SCALAR,  2, 9,   RD_VEC,    2, 0,   WR_SCALAR,  2, 9, 2.0, 9,  18.0, 18.0};
        tbl[3] = '{RD_DISABLE, 2, 0,   RD_SCALAR, 2, 127, WR_DISABLE, 0, 0, 0.0, 0,  0.0,  127.0};
        tbl[4] = '{RD_VEC,     7, 0,   RD_VEC,    2, 0,   WR_VEC,     7, 0, 0.5, 10, 5.0,  10.0};
        tbl[5] = '{RD_SCALAR,  7, 0,   RD_SCALAR, 7, 1,   WR_SCALAR,  7, 0, 3.0, 3,  0.0,  0.5};

        set_idle();
        model_clear();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check32("reset fill_ready", 32'(fill_ready), 32'd0);
        check32("reset fill_busy",  32'(fill_busy),  32'd0);

        // Constant-expectation vectors.
        foreach (tbl[i]) begin
            set_idle();
            set_read(0, tbl[i].rop0, tbl[i].ra0, tbl[i].rp0);
            set_read(1, tbl[i].rop1, tbl[i].ra1, tbl[i].rp1);
            set_write(tbl[i].wop, tbl[i].wa, tbl[i].wp, tbl[i].scale);
            step();
            check32($sformatf("tbl%0d port0", i), data_out[0][tbl[i].lane], f2b(tbl[i].exp0));
            check32($sformatf("tbl%0d port1", i), data_out[1][tbl[i].lane], f2b(tbl[i].exp1));
        end

        // Fill reg 4, no bubbles, with a conflicting and a parallel write.
        set_idle();
        fill_start = 1'b1; fill_addr = 3'd4; fill_valid = 1'b1; set_beat(99.0);
        step();
        check32("fillA busy after start", 32'(fill_busy), 32'd1);
        done_at = -1;
        for (int k = 0; k < NB; k++) begin
            set_idle();
            fill_valid = 1'b1; set_beat(k + 1.0);
            set_read(1, RD_VEC, 4, 0);
            if (k == 2) set_write(WR_VEC, 4, 0, 9.0);
            if (k == 3) set_write(WR_VEC, 1, 0, 2.0);
            if (k == 4) begin fill_start = 1'b1; fill_addr = 3'd6; end
            step();
            if (k == 2) check32("fillA write_conflict", 32'(write_conflict), 32'd1);
            if (fill_done) done_at = k + 1;
        end
        check32("fillA done edge", 32'(done_at), 32'(NB));
        set_idle();
        set_read(0, RD_SCALAR, 4, 17);
        set_read(1, RD_SCALAR, 4, 127);
        step();
        check32("fillA done one cycle", 32'(fill_done), 32'd0);
        check32("fillA reg4 lane17", data_out[0][0], f2b(2.0));
        check32("fillA reg4 lane127", data_out[1][5], f2b(8.0));
        set_idle();
        set_read(0, RD_SCALAR, 1, 3);
        set_read(1, RD_SCALAR, 4, 1);
        step();
        check32("parallel write reg1", data_out[0][0], f2b(6.0));
        check32("conflict write dropped", data_out[1][0], f2b(1.0));

        // Fill reg 3 with fill_valid low every other cycle.
        set_idle();
        fill_start = 1'b1; fill_addr = 3'd3;
        step();
        done_at = -1; done_cnt = 0;
        for (int j = 1; j <= 2 * NB + 2; j++) begin
            set_idle();
            fill_valid = (j % 2 == 0) && (j <= 2 * NB);
            set_beat(j / 2);
            step();
            if (fill_done) begin done_cnt++; done_at = j; end
        end
        check32("fillB done edge", 32'(done_at), 32'(2 * NB));
        check32("fillB done count", 32'(done_cnt), 32'd1);
        set_idle();
        set_read(0, RD_SCALAR, 3, 17);
        set_read(1, RD_SCALAR, 3, 127);
        step();
        check32("fillB reg3 lane17", data_out[0][0], f2b(2.0));
        check32("fillB reg3 lane127", data_out[1][0], f2b(8.0));

        // Reset in the middle of a fill of reg 5.
        set_idle();
        fill_start = 1'b1; fill_addr = 3'd5;
        step();
        for (int k = 0; k < 3; k++) begin
            set_idle();
            fill_valid = 1'b1; set_beat(7.0);
            set_read(0, RD_VEC, 5, 0);
            step();
        end
        set_idle();
        #3 reset_n = 1'b0;
        #1;
        check32("midreset busy", 32'(fill_busy), 32'd0);
        check32("midreset ready", 32'(fill_ready), 32'd0);
        check32("midreset data_out", data_out[0][0], 32'h0);
        model_clear();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        set_read(0, RD_VEC, 5, 0);
        set_read(1, RD_VEC, 2, 0);
        step();
        step();
        set_idle();
        fill_start = 1'b1; fill_addr = 3'd5; fill_valid = 1'b1;
        step();
        for (int k = 0; k < NB; k++) begin
            set_idle();
            fill_valid = 1'b1; set_beat(k + 1.0);
            step();
        end
        set_idle();
        set_read(0, RD_SCALAR, 5, 127);
        step();
        check32("refill reg5 lane127", data_out[0][0], f2b(8.0));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NR; p++) begin
                read_op[p]    = VecDataReadOp_t'(2'($urandom_range(0, 2)));
                read_addr[p]  = 3'($urandom);
                read_param[p] = 7'($urandom);
            end
            write_op    = VecDataWriteOp_t'(2'($urandom_range(0, 2)));
            write_addr  = 3'($urandom);
            write_param = 7'($urandom);
            for (int l = 0; l < W; l++) data_in[l] = $urandom;
            fill_start = ($urandom_range(0, 7) == 0);
            fill_addr  = 3'($urandom);
            fill_valid = ($urandom_range(0, 9) < 7);
            for (int b = 0; b < B; b++) fill_data[b] = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
